// File: rtl/conv_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_buffer
// Description : Captures CH conv result lanes at scan-timed ticks into an
//               OUT_H x OUT_W map, then streams the map out over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_buffer #(
    parameter int DW        = 8,
    parameter int CH        = 3,
    parameter int OUT_W     = 6,
    parameter int OUT_H     = 6,
    parameter int ROW_PITCH = 8,
    parameter int START_OFS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              en,
    input  logic [CH*DW-1:0]  ans_bus,
    output logic [CH*DW-1:0]  last_reg,
    output logic              cap_pulse,
    output logic              busy,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CH*DW-1:0]  rd_data,
    output logic              rd_last,
    output logic              done
);

    localparam int c_DEPTH = OUT_W * OUT_H;
    localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH + 1) : 1;
    localparam int c_RW    = (OUT_H > 1) ? $clog2(OUT_H + 1) : 1;
    localparam int c_CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int c_TW    = $clog2(START_OFS + OUT_H * ROW_PITCH + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SCAN  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    generate
        if (ROW_PITCH < OUT_W) begin : g_pitch_check
            $error("conv_result_buffer: ROW_PITCH must be >= OUT_W");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [c_TW-1:0]    r_tick;
    logic [c_TW-1:0]    r_target;
    logic [c_RW-1:0]    r_row;
    logic [c_CW-1:0]    r_col;
    logic [c_AW-1:0]    r_wr_addr;
    logic [c_AW-1:0]    r_rd_addr;
    logic [CH*DW-1:0]   r_last_reg;
    logic               r_done;
    logic [CH*DW-1:0]   r_mem [c_DEPTH];

    logic w_capture;
    logic w_row_end;
    logic w_frame_end;
    logic w_accept;
    logic w_accept_last;

    // r_target tracks START_OFS + row*ROW_PITCH + col incrementally
    assign w_capture     = (r_state == c_SCAN) && en && !clear && (r_tick == r_target);
    assign w_row_end     = (r_col == c_CW'(OUT_W - 1));
    assign w_frame_end   = w_row_end && (r_row == c_RW'(OUT_H - 1));
    assign w_accept      = (r_state == c_DRAIN) && rd_ready;
    assign w_accept_last = w_accept && (r_rd_addr == c_AW'(c_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_tick     <= '0;
            r_target   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_last_reg <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state   <= c_IDLE;
                r_tick    <= '0;
                r_target  <= '0;
                r_row     <= '0;
                r_col     <= '0;
                r_wr_addr <= '0;
                r_rd_addr <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start) begin
                            r_state   <= c_SCAN;
                            r_tick    <= '0;
                            r_target  <= c_TW'(START_OFS);
                            r_row     <= '0;
                            r_col     <= '0;
                            r_wr_addr <= '0;
                        end
                    end
                    c_SCAN: begin
                        if (en) begin
                            r_tick <= r_tick + c_TW'(1);
                        end
                        if (w_capture) begin
                            r_last_reg <= ans_bus;
                            r_wr_addr  <= r_wr_addr + c_AW'(1);
                            if (w_row_end) begin
                                r_col    <= '0;
                                r_row    <= r_row + c_RW'(1);
                                r_target <= r_target + c_TW'(ROW_PITCH - OUT_W + 1);
                            end else begin
                                r_col    <= r_col + c_CW'(1);
                                r_target <= r_target + c_TW'(1);
                            end
                            if (w_frame_end) begin
                                r_state   <= c_DRAIN;
                                r_rd_addr <= '0;
                            end
                        end
                    end
                    c_DRAIN: begin
                        if (w_accept_last) begin
                            r_state   <= c_IDLE;
                            r_rd_addr <= '0;
                            r_done    <= 1'b1;
                        end else if (w_accept) begin
                            r_rd_addr <= r_rd_addr + c_AW'(1);
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    // Map storage carries no reset so it can map onto plain RAM
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_addr] <= ans_bus;
        end
    end

    assign last_reg  = r_last_reg;
    assign cap_pulse = w_capture;
    assign busy      = (r_state != c_IDLE);
    assign rd_valid  = (r_state == c_DRAIN);
    assign rd_data   = r_mem[r_rd_addr];
    assign rd_last   = (r_state == c_DRAIN) && (r_rd_addr == c_AW'(c_DEPTH - 1));
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_result_buffer
// Description : Randomized bench for conv_result_buffer against a map-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_buffer;

    localparam int W_A   = 24;
    localparam int NA    = 36;
    localparam int OW_A  = 6;
    localparam int RP_A  = 8;
    localparam int SO_A  = 20;
    localparam int W_B   = 64;
    localparam int NB    = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic start, clear, en, rd_ready;
    logic [W_A-1:0] ans_bus;
    logic [W_A-1:0] last_reg, rd_data;
    logic cap_pulse, busy, rd_valid, rd_last, done;

    logic start_b, clear_b, en_b, rd_ready_b;
    logic [W_B-1:0] ans_b;
    logic [W_B-1:0] last_reg_b, rd_data_b;
    logic cap_pulse_b, busy_b, rd_valid_b, rd_last_b, done_b;

    int vectors = 0;
    int miscompares = 0;
    logic [W_A-1:0] exp_last = '0;

    always #5 clk = ~clk;

    conv_result_buffer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .en(en),
        .ans_bus(ans_bus), .last_reg(last_reg), .cap_pulse(cap_pulse), .busy(busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .done(done)
    );

    conv_result_buffer #(
        .DW(16), .CH(4), .OUT_W(4), .OUT_H(3), .ROW_PITCH(6), .START_OFS(5)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear_b), .en(en_b),
        .ans_bus(ans_b), .last_reg(last_reg_b), .cap_pulse(cap_pulse_b), .busy(busy_b),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b),
        .rd_last(rd_last_b), .done(done_b)
    );

    // n-th capture of a frame happens on the en-tick given by its map position
    function automatic int cap_tick_a(input int n);
        return SO_A + (n / OW_A) * RP_A + (n % OW_A);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; en = 1'b1; rd_ready = 1'b1;
        ans_bus = '1;
        start_b = 1'b0; clear_b = 1'b0; en_b = 1'b1; rd_ready_b = 1'b1; ans_b = '1;
        #2;
        vectors++;
        if (busy !== 1'b0 || cap_pulse !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
            done !== 1'b0 || last_reg !== '0) begin
            miscompares++;
            $display("FAIL reset_a: busy=%b cap=%b vld=%b last=%b done=%b last_reg=%h, want all 0",
                     busy, cap_pulse, rd_valid, rd_last, done, last_reg);
        end
        vectors++;
        if (busy_b !== 1'b0 || cap_pulse_b !== 1'b0 || rd_valid_b !== 1'b0 || done_b !== 1'b0 ||
            last_reg_b !== '0) begin
            miscompares++;
            $display("FAIL reset_b: busy=%b cap=%b vld=%b done=%b last_reg=%h, want all 0",
                     busy_b, cap_pulse_b, rd_valid_b, done_b, last_reg_b);
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || last_reg !== '0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b vld=%b last_reg=%h, want 0 0 0",
                     busy, rd_valid, last_reg);
        end
        @(posedge clk); #1;
    endtask

    // One full frame (or an aborted one) checked cycle by cycle against the map model.
    // ready_mode: 0 always ready, 1 alternate 1010.., 2 random.
    // abort_kind: 0 none, 1 clear at abort_at, 2 async reset at abort_at.
    task automatic test_frame(input int gap_at, input int gap_len, input bit en_rand,
                              input bit stray, input int ready_mode,
                              input int abort_at, input int abort_kind);
        logic [W_A-1:0] exp_mem [NA];
        int n_cap, en_ticks, cyc, rd_idx, k, first_cyc, last_cyc;
        bit exp_cap;
        n_cap = 0; en_ticks = 0; first_cyc = -1; last_cyc = -1;

        start = 1'b1; en = 1'b1; rd_ready = 1'b1; ans_bus = W_A'($urandom);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_idle_busy: got %b want 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;

        cyc = 1;
        while (n_cap < NA && cyc < 300) begin
            if (en_rand) en = ($urandom_range(0, 3) != 0);
            else en = !(cyc >= gap_at && cyc < gap_at + gap_len);
            start = stray && (cyc == 30);
            ans_bus = W_A'($urandom);
            if (cyc == abort_at) begin
                start = 1'b0;
                if (abort_kind == 1) begin
                    clear = 1'b1;
                    @(posedge clk); #1;
                    clear = 1'b0;
                    @(negedge clk);
                    vectors++;
                    if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0 ||
                        cap_pulse !== 1'b0 || last_reg !== exp_last) begin
                        miscompares++;
                        $display("FAIL clear_idle: busy=%b vld=%b done=%b cap=%b last_reg=%h want 0 0 0 0 %h",
                                 busy, rd_valid, done, cap_pulse, last_reg, exp_last);
                    end
                    @(posedge clk); #1;
                end else begin
                    #2 rst_n = 1'b0;
                    #1;
                    vectors++;
                    if (busy !== 1'b0 || cap_pulse !== 1'b0 || rd_valid !== 1'b0 ||
                        rd_last !== 1'b0 || done !== 1'b0 || last_reg !== '0) begin
                        miscompares++;
                        $display("FAIL async_reset: busy=%b cap=%b vld=%b last=%b done=%b last_reg=%h want all 0",
                                 busy, cap_pulse, rd_valid, rd_last, done, last_reg);
                    end
                    exp_last = '0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                end
                return;
            end
            @(negedge clk);
            exp_cap = en && (en_ticks == cap_tick_a(n_cap));
            vectors++;
            if (cap_pulse !== exp_cap || busy !== 1'b1 || rd_valid !== 1'b0 || last_reg !== exp_last) begin
                miscompares++;
                $display("FAIL scan_c%0d: cap=%b want %b busy=%b vld=%b last_reg=%h want %h",
                         cyc, cap_pulse, exp_cap, busy, rd_valid, last_reg, exp_last);
            end
            if (exp_cap) begin
                exp_mem[n_cap] = ans_bus;
                exp_last = ans_bus;
                if (n_cap == 0) first_cyc = cyc;
                if (n_cap == NA - 1) last_cyc = cyc;
                n_cap++;
            end
            if (en) en_ticks++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (n_cap != NA) begin
            miscompares++;
            $display("FAIL scan_timeout: captures %0d want %0d", n_cap, NA);
            return;
        end
        if (!en_rand) begin
            vectors++;
            if (first_cyc != 21 || last_cyc != 66 + gap_len) begin
                miscompares++;
                $display("FAIL capture_timing: first c%0d last c%0d want c21 c%0d",
                         first_cyc, last_cyc, 66 + gap_len);
            end
        end

        rd_idx = 0; k = 0;
        while (rd_idx < NA && k < 400) begin
            case (ready_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k % 2 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            en = 1'($urandom_range(0, 1));
            ans_bus = W_A'($urandom);
            start = stray && (k == 2);
            @(negedge clk);
            vectors++;
            if (rd_valid !== 1'b1 || busy !== 1'b1 || cap_pulse !== 1'b0 || done !== 1'b0 ||
                rd_data !== exp_mem[rd_idx] || rd_last !== (rd_idx == NA - 1) ||
                last_reg !== exp_last) begin
                miscompares++;
                $display("FAIL drain_word%0d: vld=%b busy=%b cap=%b done=%b data=%h want %h last=%b last_reg=%h want %h",
                         rd_idx, rd_valid, busy, cap_pulse, done, rd_data, exp_mem[rd_idx],
                         rd_last, last_reg, exp_last);
            end
            if (rd_ready) rd_idx++;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        rd_ready = 1'b1;
        vectors++;
        if (rd_idx != NA) begin
            miscompares++;
            $display("FAIL drain_timeout: words %0d want %0d", rd_idx, NA);
            return;
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || last_reg !== exp_last) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b busy=%b vld=%b last_reg=%h want 1 0 0 %h",
                     done, busy, rd_valid, last_reg, exp_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width: done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        test_frame(0, 0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_ready_toggle;
        test_frame(0, 0, 1'b0, 1'b0, 1, 0, 0);
    endtask

    task automatic test_en_gap;
        test_frame(39, 5, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_clear;
        test_frame(0, 0, 1'b0, 1'b0, 0, 40, 1);
        test_frame(0, 0, 1'b0, 1'b0, 2, 0, 0);
    endtask

    task automatic test_stray_start;
        test_frame(0, 0, 1'b0, 1'b1, 0, 0, 0);
    endtask

    task automatic test_async_reset;
        test_frame(0, 0, 1'b0, 1'b0, 0, 30, 2);
        test_frame(0, 0, 1'b1, 1'b0, 2, 0, 0);
    endtask

    task automatic test_params;
        logic [W_B-1:0] expm [NB];
        logic [W_B-1:0] lastb;
        int n, idx, firstc, lastc;
        bit exp_cap;
        lastb = '0; n = 0; firstc = -1; lastc = -1;
        start_b = 1'b1; en_b = 1'b1; ans_b = {$urandom, $urandom};
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int cyc = 1; cyc < 60 && n < NB; cyc++) begin
            ans_b = {$urandom, $urandom};
            @(negedge clk);
            exp_cap = ((cyc - 1) == 5 + (n / 4) * 6 + (n % 4));
            vectors++;
            if (cap_pulse_b !== exp_cap || busy_b !== 1'b1 || last_reg_b !== lastb) begin
                miscompares++;
                $display("FAIL params_scan_c%0d: cap=%b want %b busy=%b last_reg=%h want %h",
                         cyc, cap_pulse_b, exp_cap, busy_b, last_reg_b, lastb);
            end
            if (exp_cap) begin
                expm[n] = ans_b;
                lastb = ans_b;
                if (n == 0) firstc = cyc;
                if (n == NB - 1) lastc = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (n != NB || firstc != 6 || lastc != 21) begin
            miscompares++;
            $display("FAIL params_timing: captures %0d first c%0d last c%0d want 12 c6 c21",
                     n, firstc, lastc);
            return;
        end
        idx = 0;
        for (int k = 0; k < 100 && idx < NB; k++) begin
            rd_ready_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (rd_valid_b !== 1'b1 || rd_data_b !== expm[idx] || rd_last_b !== (idx == NB - 1)) begin
                miscompares++;
                $display("FAIL params_word%0d: vld=%b data=%h want %h last=%b",
                         idx, rd_valid_b, rd_data_b, expm[idx], rd_last_b);
            end
            if (rd_ready_b) idx++;
            @(posedge clk); #1;
        end
        rd_ready_b = 1'b1;
        @(negedge clk);
        vectors++;
        if (idx != NB || done_b !== 1'b1 || busy_b !== 1'b0) begin
            miscompares++;
            $display("FAIL params_done: words %0d done=%b busy=%b want 12 1 0", idx, done_b, busy_b);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_en_gap();
        test_clear();
        test_stray_start();
        test_async_reset();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
